// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer slice:
// sequencer states, address field widths and the branch displacement helper.
package pc_sequencer_pkg;

   localparam int PC_WIDTH   = 32;
   localparam int JIDX_WIDTH = 26;
   localparam int OFFS_WIDTH = 16;
   localparam logic [PC_WIDTH-1:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   // Sign-extended word offset converted to a byte displacement.
   function automatic logic [PC_WIDTH-1:0] branch_disp(input logic [OFFS_WIDTH-1:0] offs);
      branch_disp = {{14{offs[15]}}, offs, 2'b00};
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-side and fetch-side signals of the sequencer, bundled into one interface.
// The master modport drives the control inputs; the sequencer itself uses the slave modport.
interface pc_sequencer_if #(
   parameter int CNT_WIDTH = 32
);
   import pc_sequencer_pkg::*;

   logic                  stall;
   logic                  branch_taken;
   logic [OFFS_WIDTH-1:0] branch_offset;
   logic                  jump;
   logic [JIDX_WIDTH-1:0] jump_index;
   logic                  halt;
   logic                  resume;
   logic [PC_WIDTH-1:0]   pc;
   logic                  pc_valid;
   logic                  halted;
   logic [CNT_WIDTH-1:0]  retired_count;

   modport master (
      output stall, branch_taken, branch_offset, jump, jump_index, halt, resume,
      input  pc, pc_valid, halted, retired_count
   );

   modport slave (
      input  stall, branch_taken, branch_offset, jump, jump_index, halt, resume,
      output pc, pc_valid, halted, retired_count
   );

endinterface

// File: rtl/pc_sequencer_next_pc_mux.sv
// Combinational next-PC calculator: sequential, branch and jump targets.
// Jump outranks a taken branch; stall/halt are resolved by the caller.
module next_pc_mux
   import pc_sequencer_pkg::*;
(
   input  logic [PC_WIDTH-1:0]   pc,
   input  logic [OFFS_WIDTH-1:0] branch_offset,
   input  logic [JIDX_WIDTH-1:0] jump_index,
   input  logic                  jump,
   input  logic                  branch_taken,
   output logic [PC_WIDTH-1:0]   pc_plus4,
   output logic [PC_WIDTH-1:0]   next_pc
);

   logic [PC_WIDTH-1:0] branch_target;
   logic [PC_WIDTH-1:0] jump_target;

   assign pc_plus4      = pc + PC_STEP;
   assign branch_target = pc_plus4 + branch_disp(branch_offset);
   // Jumps stay inside the 256 MB region of the delay-slot address.
   assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};

   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = jump_target;
      end else if (branch_taken) begin
         next_pc = branch_target;
      end else begin
         next_pc = pc_plus4;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for the single-cycle core: BOOT/RUN/HALT sequencing,
// stall and halt handling, and a retired-instruction counter.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter int                  CNT_WIDTH    = 32
)(
   input  logic             clk,
   input  logic             reset,
   pc_sequencer_if.slave    bus
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_e                state_q, state_d;
   logic [PC_WIDTH-1:0]   pc_q, pc_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [PC_WIDTH-1:0]   pc_plus4;
   logic [PC_WIDTH-1:0]   mux_pc;

   next_pc_mux u_next_pc_mux (
      .pc            (pc_q),
      .branch_offset (bus.branch_offset),
      .jump_index    (bus.jump_index),
      .jump          (bus.jump),
      .branch_taken  (bus.branch_taken),
      .pc_plus4      (pc_plus4),
      .next_pc       (mux_pc)
   );

   // State, PC and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         cnt_q   <= {CNT_WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, PC and counter; halt outranks stall, so a halt always retires.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (bus.halt) begin
               state_d = HALT;
               cnt_d   = cnt_q + CNT_ONE;
            end else if (bus.stall) begin
               cnt_d   = cnt_q;
            end else begin
               pc_d    = mux_pc;
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         HALT: begin
            if (bus.resume) begin
               state_d = RUN;
               pc_d    = pc_plus4;
            end else begin
               state_d = HALT;
            end
         end
         default: begin
            state_d = BOOT;
            pc_d    = RESET_VECTOR;
         end
      endcase
   end

   assign bus.pc            = pc_q;
   assign bus.pc_valid      = (state_q == RUN);
   assign bus.halted        = (state_q == HALT);
   assign bus.retired_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: three instances cover the zero reset vector,
// the wrap-around vector with a narrow counter, and the upper-region jump case.
module tb_pc_sequencer;
   import pc_sequencer_pkg::*;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   pc_sequencer_if #(.CNT_WIDTH(32)) a_if ();
   pc_sequencer_if #(.CNT_WIDTH(4))  b_if ();
   pc_sequencer_if #(.CNT_WIDTH(32)) c_if ();

   pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .CNT_WIDTH(32)) u_a (
      .clk (clk), .reset (reset), .bus (a_if.slave));
   pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFF8), .CNT_WIDTH(4)) u_b (
      .clk (clk), .reset (reset), .bus (b_if.slave));
   pc_sequencer #(.RESET_VECTOR(32'h4000_0008), .CNT_WIDTH(32)) u_c (
      .clk (clk), .reset (reset), .bus (c_if.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors = vectors + 1;
      assert (obs === exp) else begin
         miscompares = miscompares + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      {a_if.stall, a_if.branch_taken, a_if.jump, a_if.halt, a_if.resume} = 5'b00000;
      a_if.branch_offset = 16'h0000;
      a_if.jump_index    = 26'h0;
      {b_if.stall, b_if.branch_taken, b_if.jump, b_if.halt, b_if.resume} = 5'b00000;
      b_if.branch_offset = 16'h0000;
      b_if.jump_index    = 26'h0;
      // C holds jump and branch high from the start; BOOT must ignore them.
      {c_if.stall, c_if.branch_taken, c_if.jump, c_if.halt, c_if.resume} = 5'b01100;
      c_if.branch_offset = 16'h0010;
      c_if.jump_index    = 26'h0000_040;

      tick(); tick(); tick();
      chk("rst_pc",     a_if.pc, 32'h0);
      chk("rst_valid",  {31'b0, a_if.pc_valid}, 32'd0);
      chk("rst_halted", {31'b0, a_if.halted}, 32'd0);
      chk("rst_cnt",    a_if.retired_count, 32'd0);
      chk("rst_b_pc",   b_if.pc, 32'hFFFF_FFF8);

      reset = 1'b0;
      #1;
      chk("boot_valid", {31'b0, a_if.pc_valid}, 32'd0);
      chk("boot_pc",    a_if.pc, 32'h0);

      tick(); // 1
      chk("run0_pc",    a_if.pc, 32'h0);
      chk("run0_valid", {31'b0, a_if.pc_valid}, 32'd1);
      chk("run0_cnt",   a_if.retired_count, 32'd0);
      chk("c_boot_pc",  c_if.pc, 32'h4000_0008);
      chk("b_run0_pc",  b_if.pc, 32'hFFFF_FFF8);
      tick(); // 2
      chk("run1_pc",    a_if.pc, 32'h4);
      chk("c_jump_pc",  c_if.pc, 32'h4000_0100);
      chk("b_wrap1_pc", b_if.pc, 32'hFFFF_FFFC);
      tick(); // 3
      chk("run2_pc",    a_if.pc, 32'h8);
      chk("b_wrap2_pc", b_if.pc, 32'h0000_0000);
      chk("c_jump2_pc", c_if.pc, 32'h4000_0100);
      chk("c_cnt",      c_if.retired_count, 32'd2);
      tick(); // 4
      chk("run3_pc",    a_if.pc, 32'hC);
      chk("run3_cnt",   a_if.retired_count, 32'd3);
      tick(); // 5
      chk("seq_pc10",   a_if.pc, 32'h10);

      a_if.branch_taken  = 1'b1;
      a_if.branch_offset = 16'hFFFE;
      tick(); // 6
      chk("br_back_pc", a_if.pc, 32'hC);
      chk("br_cnt",     a_if.retired_count, 32'd5);
      a_if.branch_taken = 1'b0;
      tick(); // 7
      chk("seq_pc10b",  a_if.pc, 32'h10);
      a_if.branch_taken  = 1'b1;
      a_if.branch_offset = 16'h0003;
      tick(); // 8
      chk("br_fwd_pc",  a_if.pc, 32'h20);
      a_if.branch_taken = 1'b0;

      a_if.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_if.jump       = (i == 1);
         a_if.jump_index = 26'h0000_100;
         tick(); // 9..11
         chk("stall_pc",    a_if.pc, 32'h20);
         chk("stall_valid", {31'b0, a_if.pc_valid}, 32'd1);
         chk("stall_cnt",   a_if.retired_count, 32'd7);
      end
      a_if.stall = 1'b0;
      a_if.jump  = 1'b0;
      tick(); // 12
      chk("unstall_pc", a_if.pc, 32'h24);
      tick(); tick(); tick(); // 13..15
      chk("pre_halt_pc", a_if.pc, 32'h30);
      chk("pre_halt_cnt", a_if.retired_count, 32'd11);

      a_if.halt  = 1'b1;
      a_if.stall = 1'b1;
      tick(); // 16
      chk("halt_pc",     a_if.pc, 32'h30);
      chk("halt_flag",   {31'b0, a_if.halted}, 32'd1);
      chk("halt_valid",  {31'b0, a_if.pc_valid}, 32'd0);
      chk("halt_cnt",    a_if.retired_count, 32'd12);
      a_if.halt  = 1'b0;
      a_if.stall = 1'b0;
      a_if.jump  = 1'b1;
      tick(); // 17
      chk("halt_hold_pc",  a_if.pc, 32'h30);
      chk("halt_hold_flg", {31'b0, a_if.halted}, 32'd1);
      a_if.jump   = 1'b0;
      a_if.resume = 1'b1;
      tick(); // 18
      chk("resume_pc",    a_if.pc, 32'h34);
      chk("resume_flag",  {31'b0, a_if.halted}, 32'd0);
      chk("resume_valid", {31'b0, a_if.pc_valid}, 32'd1);
      chk("resume_cnt",   a_if.retired_count, 32'd12);
      tick(); // 19, resume still high while running
      chk("resume_run_pc",  a_if.pc, 32'h38);
      chk("resume_run_cnt", a_if.retired_count, 32'd13);
      chk("b_cnt_wrap",     {28'b0, b_if.retired_count}, 32'd2);
      chk("b_pc_19",        b_if.pc, 32'h0000_0040);
      a_if.resume        = 1'b0;
      a_if.jump          = 1'b1;
      a_if.branch_taken  = 1'b1;
      a_if.jump_index    = 26'h0000_010;
      tick(); // 20
      chk("jump_beats_br", a_if.pc, 32'h40);
      chk("jump_cnt",      a_if.retired_count, 32'd14);

      #2;
      reset = 1'b1;
      #1;
      chk("async_pc",    a_if.pc, 32'h0);
      chk("async_cnt",   a_if.retired_count, 32'd0);
      chk("async_valid", {31'b0, a_if.pc_valid}, 32'd0);
      chk("async_b_pc",  b_if.pc, 32'hFFFF_FFF8);
      chk("async_b_cnt", {28'b0, b_if.retired_count}, 32'd0);
      tick();
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter register for the single-cycle MIPS core and sequences fetch.
- Each cycle, picks the next PC from sequential (+4), taken branch, or jump. Supports stall, halt and resume.
- Sits between control/branch-compare logic and instruction memory. Drives the fetch address and a fetch-valid qualifier.
- Keeps a retired-instruction counter for debug.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset (must be word aligned).
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hold PC this cycle (memory/hazard wait)
- branch_taken  input  1  conditional branch resolved taken
- branch_offset  input  16  signed word offset from instruction imm field
- jump  input  1  J-type jump
- jump_index  input  26  instr_index field of J-type
- halt  input  1  halt instruction decoded at current pc
- resume  input  1  leave HALT state
- pc  output  32  current fetch address
- pc_valid  output  1  pc is a valid fetch this cycle
- halted  output  1  sequencer is in HALT
- retired_count  output  CNT_WIDTH  instructions completed since reset

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: pc=RESET_VECTOR, state=BOOT, pc_valid=0, halted=0, retired_count=0. Reset asserted mid-operation overrides everything immediately.
- pc_plus4 = pc + 32'd4, modulo 2^32. 0xFFFF_FFFC wraps to 0x0000_0000.
- Branch target = pc_plus4 + ({{14{branch_offset[15]}}, branch_offset, 2'b00}), modulo 2^32.
- Jump target = {pc_plus4[31:28], jump_index, 2'b00}.
- pc[1:0] is always 2'b00; every target is aligned by construction.
- States are BOOT, RUN and HALT.
- BOOT:
  - Lasts exactly one cycle after reset deasserts, then goes to RUN.
  - pc stays at RESET_VECTOR and pc_valid=1 from the first RUN cycle.
  - All inputs are ignored in BOOT.
- RUN: pc_valid=1, halted=0. Priority each cycle is halt > stall > jump > branch_taken > sequential.
  - halt: go to HALT; pc holds; pc_valid=0 next cycle; retired_count +1 (the halt retires).
  - stall: pc holds; retired_count holds; pc_valid remains 1.
  - jump: pc <= jump target; retired_count +1.
  - branch_taken: pc <= branch target; retired_count +1.
  - none of the above: pc <= pc_plus4; retired_count +1.
  - If jump and branch_taken are both high, jump wins.
  - If stall and halt are both high, halt wins.
- HALT: pc_valid=0, halted=1; pc and retired_count hold.
  - resume=1: pc <= pc_plus4, go to RUN (the halt instruction is skipped).
  - All other inputs are ignored.
  - resume is ignored in RUN and BOOT.
- Counter wrap: retired_count wraps modulo 2^CNT_WIDTH with no saturation.
- Output timing: all outputs are registered or decoded directly from state and pc. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package (cpu_pkg): state enum {BOOT, RUN, HALT}, PC_STEP=4, PC_WIDTH=32, JIDX_WIDTH=26, OFFS_WIDTH=16.
- One sub-module, next_pc_mux: a combinational target calculator with pc, branch_offset, jump_index and the select inputs. It returns pc_plus4 and the selected next PC.
- The FSM, PC register and counter stay in pc_sequencer.

Test Plan:
- Reset/boot: assert reset for 3 cycles, release -> pc=0x0 and pc_valid=0 for 1 cycle, then pc_valid=1. Over 4 free-running cycles pc=0x0,0x4,0x8,0xC and retired_count=3 after the third advance.
- Branch: at pc=0x10, branch_taken=1, branch_offset=16'hFFFE -> next pc=0x0C. With offset=16'h0003 from pc=0x10 -> next pc=0x20.
- Jump priority and region: pc=0x4000_0008, jump=1, branch_taken=1, jump_index=26'h0000_040 -> pc=0x4000_0100 (jump beats branch, upper nibble kept).
- Stall: stall=1 for 3 cycles at pc=0x20 -> pc stays 0x20, pc_valid=1, retired_count unchanged. Release -> pc=0x24.
- Halt/resume: halt at pc=0x30 -> halted=1, pc_valid=0, pc=0x30 while held. resume pulse -> pc=0x34, RUN. resume during RUN has no effect.
- Wrap and async reset: run from RESET_VECTOR=0xFFFF_FFF8 -> 0xFFFF_FFFC then 0x0000_0000. Assert reset asynchronously mid-cycle -> pc=RESET_VECTOR and retired_count=0 before the next clk edge.
